// File: rtl/sdram_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// sdram_prefetch_buffer
//
// Single-line read prefetch buffer on the Wishbone path in front of the SDRAM
// wrapper. A read miss refills one aligned line of LINE_WORDS words from SDRAM
// using single-beat reads. The beat that carries the requested word acks the
// CPU right away (early restart). Later reads of the same line are served one
// cycle after the request. Writes are forwarded to SDRAM unchanged.
//
// Build option (macro SDRAM_PF_WRITE_UPDATE_EN):
//   defined     - a write to a valid word of the buffered line merges its
//                 selected byte lanes into the buffer; the line stays valid.
//   not defined - a write whose tag matches the buffered line invalidates
//                 the whole line.
//   A write with a non-matching tag never touches the buffer in either mode.
//
// Ports:
//   wb_clk_i, wb_rst_n_i   clock (rising edge), asynchronous active-low reset
//   wbs_*                  slave side (CPU / user bus), Wishbone classic
//   wbm_*                  master side toward the SDRAM Wishbone wrapper
//   dbg_state_o            current FSM state (0 IDLE, 1 FILL, 2 WRITE)
//
// Handshake: a slave request is cyc&stb. The master holds it until it sees the
// one-cycle wbs_ack_o pulse, so a request seen while wbs_ack_o=1 is the one
// being acked and is ignored. At most one slave request is outstanding. On the
// master side cyc/stb/adr are held until wbm_ack_i. They then drop for at least
// one cycle before the next transfer.
// -----------------------------------------------------------------------------
module sdram_prefetch_buffer #(
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 32
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [ADDR_W-1:0] wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [3:0]        wbm_sel_o,
  output logic [ADDR_W-1:0] wbm_adr_o,
  output logic [31:0]       wbm_dat_o,
  input  logic              wbm_ack_i,
  input  logic [31:0]       wbm_dat_i,
  output logic [1:0]        dbg_state_o
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t                  r_state;
  logic [TAG_W-1:0]        r_tag;
  logic                    r_line_valid;
  logic [LINE_WORDS-1:0]   r_word_valid;
  logic [31:0]             r_data [LINE_WORDS];
  logic                    r_pend;
  logic [IDX_W-1:0]        r_pend_idx;
  logic [IDX_W-1:0]        r_beat;

  logic [IDX_W-1:0]        w_idx;
  logic [TAG_W-1:0]        w_tag;
  logic                    w_req;
  logic                    w_tag_hit;
  logic                    w_store;
  logic                    w_store_here;
  logic                    w_word_hit;
  logic                    w_rd_hit;
  logic [31:0]             w_hit_data;

  assign w_idx = wbs_adr_i[2+IDX_W-1:2];
  assign w_tag = wbs_adr_i[ADDR_W-1:2+IDX_W];

  // A pending miss keeps its strobe asserted; it is not a new request.
  assign w_req = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & ~r_pend;

  assign w_tag_hit    = r_line_valid && (w_tag == r_tag);
  assign w_store      = (r_state == S_FILL) && wbm_cyc_o && wbm_ack_i;
  // The word landing this cycle counts as valid, so a hit on it is served
  // next cycle with the freshly returned data.
  assign w_store_here = w_store && (r_beat == w_idx);
  assign w_word_hit   = w_tag_hit && (r_word_valid[w_idx] || w_store_here);
  assign w_hit_data   = w_store_here ? wbm_dat_i : r_data[w_idx];
  assign w_rd_hit     = w_req && !wbs_we_i && w_word_hit && (r_state != S_WRITE);

`ifdef SDRAM_PF_WRITE_UPDATE_EN
  logic [31:0] w_merge;
  always_comb begin
    w_merge = r_data[w_idx];
    for (int b = 0; b < 4; b++) begin
      if (wbs_sel_i[b]) w_merge[8*b +: 8] = wbs_dat_i[8*b +: 8];
    end
  end
`endif

  assign dbg_state_o = r_state;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state      <= S_IDLE;
      r_tag        <= '0;
      r_line_valid <= 1'b0;
      r_word_valid <= '0;
      for (int i = 0; i < LINE_WORDS; i++) r_data[i] <= '0;
      r_pend       <= 1'b0;
      r_pend_idx   <= '0;
      r_beat       <= '0;
      wbs_ack_o    <= 1'b0;
      wbs_dat_o    <= '0;
      wbm_cyc_o    <= 1'b0;
      wbm_stb_o    <= 1'b0;
      wbm_we_o     <= 1'b0;
      wbm_sel_o    <= '0;
      wbm_adr_o    <= '0;
      wbm_dat_o    <= '0;
    end else begin
      wbs_ack_o <= 1'b0;

      if (w_store) begin
        r_data[r_beat]       <= wbm_dat_i;
        r_word_valid[r_beat] <= 1'b1;
      end

      // Hits are served from IDLE and from FILL alike.
      if (w_rd_hit) begin
        wbs_ack_o <= 1'b1;
        wbs_dat_o <= w_hit_data;
      end

      case (r_state)
        S_IDLE: begin
          if (w_req && !w_rd_hit) begin
            if (wbs_we_i) begin
              r_state   <= S_WRITE;
              wbm_cyc_o <= 1'b1;
              wbm_stb_o <= 1'b1;
              wbm_we_o  <= 1'b1;
              wbm_sel_o <= wbs_sel_i;
              wbm_adr_o <= wbs_adr_i;
              wbm_dat_o <= wbs_dat_i;
`ifdef SDRAM_PF_WRITE_UPDATE_EN
              if (w_tag_hit && r_word_valid[w_idx]) r_data[w_idx] <= w_merge;
`else
              if (w_tag_hit) r_line_valid <= 1'b0;
`endif
            end else begin
              // Read miss: claim the line and start beat 0 next cycle.
              r_state      <= S_FILL;
              r_tag        <= w_tag;
              r_line_valid <= 1'b1;
              r_word_valid <= '0;
              r_pend       <= 1'b1;
              r_pend_idx   <= w_idx;
              r_beat       <= '0;
              wbm_cyc_o    <= 1'b1;
              wbm_stb_o    <= 1'b1;
              wbm_we_o     <= 1'b0;
              wbm_sel_o    <= 4'hF;
              wbm_adr_o    <= {w_tag, {IDX_W{1'b0}}, 2'b00};
            end
          end
        end

        S_FILL: begin
          if (r_pend) begin
            if (!wbs_cyc_i) begin
              r_pend <= 1'b0;           // requester gave up; keep refilling
            end else if (w_store && (r_beat == r_pend_idx)) begin
              wbs_ack_o <= 1'b1;        // early restart
              wbs_dat_o <= wbm_dat_i;
              r_pend    <= 1'b0;
            end
          end

          if (w_store) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            if (r_beat == LAST_BEAT) r_state <= S_IDLE;
            else                     r_beat  <= r_beat + IDX_W'(1);
          end else if (!wbm_cyc_o) begin
            // One idle cycle after each ack, then the next ascending beat.
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_adr_o <= {r_tag, r_beat, 2'b00};
          end
        end

        S_WRITE: begin
          if (wbm_cyc_o && wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbs_ack_o <= wbs_cyc_i;
            r_state   <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
